// File: rtl/cliff_pkg.sv
// Shared types and constants for the cliff game sequencer.
package cliff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOSE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_e;

  localparam int unsigned START_IDX = 7;
  localparam int unsigned GROUP_W   = 3;
  localparam int unsigned SPEED_MAX = 2;
  localparam int unsigned POS_MIN   = 1;
  localparam int unsigned POS_MAX   = 14;

endpackage

// File: rtl/cliff_game_ctrl_if.sv
// Button pulses, cliff bounds and status/display outputs of the game sequencer.
interface cliff_game_ctrl_if;
  logic        start_p;
  logic        left_p;
  logic        right_p;
  logic        faster_p;
  logic        slower_p;
  logic [2:0]  bound_l;
  logic [2:0]  bound_r;
  logic [1:0]  state;
  logic [3:0]  pos;
  logic [1:0]  speed;
  logic [1:0]  dir;
  logic        game_tick;
  logic        lose;
  logic [15:0] led;

  modport master (
    output start_p, left_p, right_p, faster_p, slower_p, bound_l, bound_r,
    input  state, pos, speed, dir, game_tick, lose, led
  );

  modport slave (
    input  start_p, left_p, right_p, faster_p, slower_p, bound_l, bound_r,
    output state, pos, speed, dir, game_tick, lose, led
  );
endinterface

// File: rtl/cliff_tick_gen.sv
// Speed-selected game tick: reloadable down-counter, one-cycle pulse at zero.
module cliff_tick_gen #(
  parameter int unsigned TICK_SLOW = 50_000_000,
  parameter int unsigned TICK_MED  = 12_500_000,
  parameter int unsigned TICK_FAST = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_load,
  input  logic [1:0] i_speed,
  output logic       o_tick
);

  localparam int unsigned P_MAX0 = (TICK_SLOW > TICK_MED) ? TICK_SLOW : TICK_MED;
  localparam int unsigned P_MAX  = (P_MAX0 > TICK_FAST) ? P_MAX0 : TICK_FAST;
  localparam int unsigned CNT_W  = $clog2(P_MAX);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_reload;
  logic             r_tick;

  // Reload value for the currently selected speed.
  always_comb begin
    w_reload = CNT_W'(TICK_FAST - 1);
    case (i_speed)
      2'd0:    w_reload = CNT_W'(TICK_SLOW - 1);
      2'd1:    w_reload = CNT_W'(TICK_MED - 1);
      default: w_reload = CNT_W'(TICK_FAST - 1);
    endcase
  end

  // Down-counter; disabled means cleared so no tick can be pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= w_reload;
      r_tick <= 1'b0;
    end else if (i_en) begin
      if (r_cnt == '0) begin
        r_cnt  <= w_reload;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt - 1'b1;
        r_tick <= 1'b0;
      end
    end else begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/cliff_game_ctrl.sv
// Cliff game sequencer: game FSM, player position/speed/drift, lose check, LED frame.
module cliff_game_ctrl
  import cliff_pkg::*;
#(
  parameter int unsigned TICK_SLOW  = 50_000_000,
  parameter int unsigned TICK_MED   = 12_500_000,
  parameter int unsigned TICK_FAST  = 5_000_000,
  parameter int unsigned START_IDX  = cliff_pkg::START_IDX,
  parameter int unsigned BLINK_HALF = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  cliff_game_ctrl_if.slave  bus
);

  localparam int unsigned BLINK_W   = $clog2(BLINK_HALF + 1);
  localparam logic [3:0]  START_POS = 4'(START_IDX);

  state_e             r_state;
  dir_e               r_dir;
  logic [3:0]         r_pos;
  logic [1:0]         r_speed;
  logic               r_lose;
  logic               r_phase;
  logic [BLINK_W-1:0] r_blink;

  logic [3:0]  w_cliff_l;
  logic [3:0]  w_cliff_r;
  logic        w_hit;
  logic        w_tick;
  logic        w_tick_en;
  logic        w_tick_load;
  logic [1:0]  w_speed_nxt;
  logic [3:0]  w_pos_tick;
  logic [15:0] w_people;
  logic [15:0] w_led;

  assign w_cliff_l   = 4'd15 - {1'b0, bus.bound_l};
  assign w_cliff_r   = {1'b0, bus.bound_r};
  assign w_hit       = (r_pos >= w_cliff_l) || (r_pos <= w_cliff_r);
  // Abort and lose both leave RUN, so the tick must not fire on that edge.
  assign w_tick_en   = (r_state == ST_RUN) && !bus.start_p && !w_hit;
  assign w_tick_load = (r_state == ST_IDLE) && bus.start_p;

  cliff_tick_gen #(
    .TICK_SLOW (TICK_SLOW),
    .TICK_MED  (TICK_MED),
    .TICK_FAST (TICK_FAST)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_tick_en),
    .i_load  (w_tick_load),
    .i_speed (r_speed),
    .o_tick  (w_tick)
  );

  // Saturating speed update; faster wins when both pulses arrive.
  always_comb begin
    w_speed_nxt = r_speed;
    if (bus.faster_p) begin
      if (r_speed < 2'(SPEED_MAX)) w_speed_nxt = r_speed + 2'd1;
    end else if (bus.slower_p && (r_speed != '0)) begin
      w_speed_nxt = r_speed - 2'd1;
    end
  end

  // Position after a game tick in the current drift direction.
  always_comb begin
    w_pos_tick = r_pos;
    if (r_dir == DIR_LEFT)       w_pos_tick = r_pos + 4'd1;
    else if (r_dir == DIR_RIGHT) w_pos_tick = r_pos - 4'd1;
  end

  // Game FSM with position, speed, drift, lose flag and blink phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pos   <= START_POS;
      r_speed <= '0;
      r_dir   <= DIR_NONE;
      r_lose  <= 1'b0;
      r_phase <= 1'b0;
      r_blink <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_speed <= w_speed_nxt;
          if (bus.start_p) begin
            r_state <= ST_RUN;
            r_dir   <= DIR_NONE;
          end else if (bus.left_p) begin
            if (r_pos < 4'(POS_MAX)) r_pos <= r_pos + 4'd1;
          end else if (bus.right_p) begin
            if (r_pos > 4'(POS_MIN)) r_pos <= r_pos - 4'd1;
          end
        end
        ST_RUN: begin
          r_speed <= w_speed_nxt;
          if (bus.start_p) begin
            r_state <= ST_IDLE;
            r_pos   <= START_POS;
            r_dir   <= DIR_NONE;
          end else if (w_hit) begin
            r_state <= ST_LOSE;
            r_dir   <= DIR_NONE;
            r_lose  <= 1'b1;
            r_phase <= 1'b1;
            r_blink <= '0;
          end else begin
            if (w_tick) r_pos <= w_pos_tick;
            if (bus.left_p)       r_dir <= DIR_LEFT;
            else if (bus.right_p) r_dir <= DIR_RIGHT;
          end
        end
        ST_LOSE: begin
          if (bus.start_p) begin
            r_state <= ST_IDLE;
            r_pos   <= START_POS;
            r_speed <= '0;
            r_dir   <= DIR_NONE;
            r_lose  <= 1'b0;
            r_phase <= 1'b0;
            r_blink <= '0;
          end else if (r_blink == BLINK_W'(BLINK_HALF - 1)) begin
            r_blink <= '0;
            r_phase <= ~r_phase;
          end else begin
            r_blink <= r_blink + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Three-wide player group centred on pos; bits outside 0..15 fall off.
  always_comb begin
    w_people = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      w_people[i] = ({1'b0, r_pos} == 5'(i + 1)) ||
                    ({1'b0, r_pos} == 5'(i)) ||
                    (({1'b0, r_pos} + 5'd1) == 5'(i));
    end
  end

  // LED frame selected by game state.
  always_comb begin
    w_led = '0;
    case (r_state)
      ST_IDLE: w_led = w_people | (16'd1 << w_cliff_l) | (16'd1 << w_cliff_r);
      ST_RUN:  w_led = w_people;
      ST_LOSE: w_led = r_phase ? '1 : '0;
      default: w_led = '0;
    endcase
  end

  assign bus.state     = r_state;
  assign bus.pos       = r_pos;
  assign bus.speed     = r_speed;
  assign bus.dir       = r_dir;
  assign bus.game_tick = w_tick;
  assign bus.lose      = r_lose;
  assign bus.led       = w_led;

endmodule

// File: tb/tb_cliff_game_ctrl.sv
// Directed bench for cliff_game_ctrl with a cycle-level reference model.
module tb_cliff_game_ctrl;

  localparam int TS = 8, TM = 4, TF = 2, BH = 3, SI = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cliff_game_ctrl_if bus ();

  cliff_game_ctrl #(
    .TICK_SLOW  (TS),
    .TICK_MED   (TM),
    .TICK_FAST  (TF),
    .START_IDX  (SI),
    .BLINK_HALF (BH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state, m_pos, m_speed, m_dir, m_left, m_age;
  bit m_tick;
  int ps;
  bit hit;

  function automatic int period(input int s);
    if (s == 0) return TS;
    if (s == 1) return TM;
    return TF;
  endfunction

  function automatic int adj(input int s, input bit f, input bit sl);
    if (f) return (s < 2) ? s + 1 : s;
    if (sl) return (s > 0) ? s - 1 : s;
    return s;
  endfunction

  function automatic logic [15:0] model_led();
    logic [15:0] v;
    v = '0;
    if (m_state == 2) return ((m_age / BH) % 2 == 0) ? 16'hFFFF : 16'h0000;
    for (int p = m_pos - 1; p <= m_pos + 1; p++)
      if (p >= 0 && p <= 15) v[p] = 1'b1;
    if (m_state == 0) begin
      v[15 - int'(bus.bound_l)] = 1'b1;
      v[int'(bus.bound_r)] = 1'b1;
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_pos = SI; m_speed = 0; m_dir = 0;
      m_left = 0; m_age = 0; m_tick = 0;
    end else begin
      ps = m_speed;
      case (m_state)
        0: begin
          m_speed = adj(ps, bus.faster_p, bus.slower_p);
          m_tick = 0;
          if (bus.start_p) begin
            m_state = 1; m_dir = 0; m_left = period(ps);
          end else if (bus.left_p) begin
            if (m_pos < 14) m_pos++;
          end else if (bus.right_p) begin
            if (m_pos > 1) m_pos--;
          end
        end
        1: begin
          hit = (m_pos >= 15 - int'(bus.bound_l)) || (m_pos <= int'(bus.bound_r));
          m_speed = adj(ps, bus.faster_p, bus.slower_p);
          if (bus.start_p) begin
            m_state = 0; m_pos = SI; m_dir = 0; m_tick = 0;
          end else if (hit) begin
            m_state = 2; m_dir = 0; m_tick = 0; m_age = 0;
          end else begin
            if (m_tick) m_pos += (m_dir == 1) ? 1 : (m_dir == 2) ? -1 : 0;
            if (bus.left_p) m_dir = 1;
            else if (bus.right_p) m_dir = 2;
            m_left--;
            if (m_left == 0) begin
              m_tick = 1; m_left = period(ps);
            end else m_tick = 0;
          end
        end
        default: begin
          if (bus.start_p) begin
            m_state = 0; m_pos = SI; m_speed = 0; m_dir = 0; m_age = 0;
          end else m_age++;
        end
      endcase
    end
  end

  // Every cycle the design is out of reset, all outputs must match the model.
  always @(negedge clk) begin
    if (cmp_on && rst_n) begin
      chk("m_state", 32'(bus.state), 32'(m_state));
      chk("m_pos",   32'(bus.pos),   32'(m_pos));
      chk("m_speed", 32'(bus.speed), 32'(m_speed));
      chk("m_dir",   32'(bus.dir),   32'(m_dir));
      chk("m_tick",  32'(bus.game_tick), 32'(m_tick));
      chk("m_lose",  32'(bus.lose),  32'(m_state == 2));
      chk("m_led",   32'(bus.led),   32'(model_led()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.start_p = 0; bus.left_p = 0; bus.right_p = 0;
    bus.faster_p = 0; bus.slower_p = 0;
  endtask

  // Drive a one-cycle pulse pattern {start,left,right,faster,slower}.
  task automatic pulse(input logic [4:0] p);
    {bus.start_p, bus.left_p, bus.right_p, bus.faster_p, bus.slower_p} = p;
    cyc();
    clr();
  endtask

  localparam logic [4:0] P_START = 5'b10000, P_LEFT = 5'b01000, P_RIGHT = 5'b00100,
                         P_FAST = 5'b00010, P_SLOW = 5'b00001;

  int n, ticks;

  initial begin
    clr();
    bus.bound_l = 3'd0;
    bus.bound_r = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_on = 1'b1;

    // 1: reset frame
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_pos",   32'(bus.pos),   32'd7);
    chk("rst_speed", 32'(bus.speed), 32'd0);
    chk("rst_led",   32'(bus.led),   32'h81C1);
    chk("rst_tick",  32'(bus.game_tick), 32'd0);

    // 2: IDLE moves and speed, saturating
    repeat (8) pulse(P_LEFT);
    chk("idle_pos_max", 32'(bus.pos), 32'd14);
    repeat (20) pulse(P_RIGHT);
    chk("idle_pos_min", 32'(bus.pos), 32'd1);
    chk("idle_led_p1",  32'(bus.led), 32'h8007);
    repeat (3) pulse(P_FAST);
    chk("idle_spd_max", 32'(bus.speed), 32'd2);
    repeat (3) pulse(P_SLOW);
    chk("idle_spd_min", 32'(bus.speed), 32'd0);
    repeat (6) pulse(P_LEFT);
    chk("idle_pos_back", 32'(bus.pos), 32'd7);

    // 3: run left at speed 0 until falling off the left cliff
    pulse(P_START);
    chk("run_state", 32'(bus.state), 32'd1);
    chk("run_led",   32'(bus.led),   32'h01C0);
    pulse(P_LEFT);
    ticks = 0; n = 0;
    while (bus.state !== 2'd2 && n < 200) begin
      if (bus.game_tick) ticks++;
      cyc(); n++;
    end
    chk("t3_lose_state", 32'(bus.state), 32'd2);
    chk("t3_ticks",      32'(ticks),     32'd8);
    chk("t3_pos",        32'(bus.pos),   32'd15);
    chk("t3_lose",       32'(bus.lose),  32'd1);

    // 5a: exit LOSE
    pulse(P_START);
    chk("exit_state", 32'(bus.state), 32'd0);
    chk("exit_pos",   32'(bus.pos),   32'd7);
    chk("exit_dir",   32'(bus.dir),   32'd0);

    // 4: right cliff at depth 5, fast speed, blink pattern
    bus.bound_r = 3'd5;
    repeat (2) pulse(P_FAST);
    pulse(P_START);
    pulse(P_RIGHT);
    n = 0;
    while (bus.state !== 2'd2 && n < 50) begin
      cyc(); n++;
    end
    chk("t4_lose_state", 32'(bus.state), 32'd2);
    chk("t4_pos",        32'(bus.pos),   32'd5);
    chk("t4_lose",       32'(bus.lose),  32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("t4_blink", 32'(bus.led), (i < 3) ? 32'hFFFF : 32'h0000);
      cyc();
    end
    pulse(P_LEFT | P_SLOW);
    chk("t4_ign_pos",   32'(bus.pos),   32'd5);
    chk("t4_ign_speed", 32'(bus.speed), 32'd2);
    pulse(P_START);
    chk("t4_exit_speed", 32'(bus.speed), 32'd0);
    chk("t4_exit_lose",  32'(bus.lose),  32'd0);

    // bounds already violated when starting
    bus.bound_r = 3'd7;
    pulse(P_START);
    chk("pre_hit_run",  32'(bus.state), 32'd1);
    cyc();
    chk("pre_hit_lose", 32'(bus.state), 32'd2);
    pulse(P_START);
    bus.bound_r = 3'd0;

    // 5b: abort in the same cycle as a tick
    pulse(P_START);
    pulse(P_LEFT);
    n = 0;
    while (!bus.game_tick && n < 20) begin
      cyc(); n++;
    end
    chk("t5_tick_seen", 32'(bus.game_tick), 32'd1);
    pulse(P_START);
    chk("t5_abort_state", 32'(bus.state), 32'd0);
    chk("t5_abort_pos",   32'(bus.pos),   32'd7);
    chk("t5_abort_tick",  32'(bus.game_tick), 32'd0);

    // 6: both directions -> left; async reset mid-RUN
    pulse(P_START);
    pulse(P_LEFT | P_RIGHT);
    chk("t6_dir_left", 32'(bus.dir), 32'd1);
    pulse(P_FAST);
    chk("t6_speed", 32'(bus.speed), 32'd1);
    repeat (2) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_state", 32'(bus.state), 32'd0);
    chk("t6_rst_pos",   32'(bus.pos),   32'd7);
    chk("t6_rst_speed", 32'(bus.speed), 32'd0);
    chk("t6_rst_dir",   32'(bus.dir),   32'd0);
    chk("t6_rst_led",   32'(bus.led),   32'h81C1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.game_tick) ticks++;
      cyc();
    end
    chk("t6_no_tick", 32'(ticks), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
